// File: rtl/jpeg_dct_seq.sv
// Control sequencer for one 8x8 2-D DCT block: row pass from the input BRAM,
// column pass from the transpose memory, then 32 packed coefficient writes.
module jpeg_dct_seq #(
  parameter int DCT_LAT = 3
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       abort_i,
  output logic       busy_o,
  output logic       done_o,
  output logic [5:0] rdc_o,
  output logic       rden_o,
  output logic       reg1en_o,
  output logic       mux1_o,
  output logic       dcten_o,
  output logic       twr_o,
  output logic       trd_o,
  output logic [1:0] mux2_o,
  output logic       wren_o,
  output logic [4:0] wrc_o
);

  localparam logic [5:0] C_T0   = 6'(17 + DCT_LAT);
  localparam logic [5:0] C_TW0  = 6'(2 + DCT_LAT);
  localparam logic [5:0] C_W0   = 6'(18 + 2 * DCT_LAT);
  localparam logic [5:0] C_TEND = 6'(50 + 2 * DCT_LAT);
  localparam logic [5:0] C_TWL  = C_TW0 + 6'd14;
  localparam logic [5:0] C_TRL  = C_T0 + 6'd28;
  localparam logic [5:0] C_DCL  = C_T0 + 6'd29;
  localparam logic [5:0] C_WL   = C_W0 + 6'd31;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ROW,
    S_GAP,
    S_COL,
    S_DONE
  } state_t;

  state_t     r_state;
  logic [5:0] r_t;
  logic       r_busy, r_done, r_rden, r_reg1en, r_mux1, r_dcten, r_twr, r_trd, r_wren;
  logic [5:0] r_rdc;
  logic [1:0] r_mux2;
  logic [4:0] r_wrc;

  logic [5:0] w_te;
  logic [1:0] w_cofs;
  logic       w_tofs0;
  logic [4:0] w_wofs;
  logic       w_rden, w_reg1en, w_dcten, w_mux1, w_twr, w_trd, w_wren, w_clr;
  logic [5:0] w_rdc;

  // Decode of the in-block cycle number that the next edge will present.
  always_comb begin
    w_te     = (r_state == S_IDLE) ? 6'd0 : r_t + 6'd1;
    w_cofs   = w_te[1:0] - C_T0[1:0];
    w_tofs0  = w_te[0] ^ C_TW0[0];
    w_wofs   = w_te[4:0] - C_W0[4:0];
    w_rden   = (w_te <= 6'd15);
    w_rdc    = w_rden ? w_te : 6'd15;
    w_reg1en = w_te[0] && (w_te <= 6'd15);
    w_dcten  = (!w_te[0] && (w_te >= 6'd2) && (w_te <= 6'd16)) ||
               ((w_te > C_T0) && (w_te <= C_DCL) && (w_cofs == 2'd1));
    w_mux1   = (w_te >= C_T0);
    w_twr    = (w_te >= C_TW0) && (w_te <= C_TWL) && !w_tofs0;
    w_trd    = (w_te >= C_T0) && (w_te <= C_TRL) && (w_cofs == 2'd0);
    w_wren   = (w_te >= C_W0) && (w_te <= C_WL);
    w_clr    = (abort_i && (r_state != S_IDLE)) || (r_state == S_DONE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i || w_clr) begin
      r_state  <= S_IDLE;
      r_t      <= 6'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_rden   <= 1'b0;
      r_rdc    <= 6'd0;
      r_reg1en <= 1'b0;
      r_mux1   <= 1'b0;
      r_dcten  <= 1'b0;
      r_twr    <= 1'b0;
      r_trd    <= 1'b0;
      r_wren   <= 1'b0;
      r_mux2   <= 2'd0;
      r_wrc    <= 5'd0;
    end else if ((r_state == S_IDLE && start_i) ||
                 (r_state != S_IDLE && w_te != C_TEND)) begin
      r_t      <= w_te;
      r_state  <= (w_te <= 6'd16) ? S_ROW : ((w_te < C_T0) ? S_GAP : S_COL);
      r_busy   <= 1'b1;
      r_done   <= 1'b0;
      r_rden   <= w_rden;
      r_rdc    <= w_rdc;
      r_reg1en <= w_reg1en;
      r_mux1   <= w_mux1;
      r_dcten  <= w_dcten;
      r_twr    <= w_twr;
      r_trd    <= w_trd;
      r_wren   <= w_wren;
      if (w_wren) begin
        r_wrc  <= w_wofs;
        r_mux2 <= w_wofs[1:0];
      end
    end else if (r_state != S_IDLE) begin
      // Final cycle: only done_o is raised; addresses hold until IDLE.
      r_t      <= w_te;
      r_state  <= S_DONE;
      r_busy   <= 1'b0;
      r_done   <= 1'b1;
      r_rden   <= 1'b0;
      r_reg1en <= 1'b0;
      r_mux1   <= 1'b0;
      r_dcten  <= 1'b0;
      r_twr    <= 1'b0;
      r_trd    <= 1'b0;
      r_wren   <= 1'b0;
    end
  end

  assign busy_o   = r_busy;
  assign done_o   = r_done;
  assign rdc_o    = r_rdc;
  assign rden_o   = r_rden;
  assign reg1en_o = r_reg1en;
  assign mux1_o   = r_mux1;
  assign dcten_o  = r_dcten;
  assign twr_o    = r_twr;
  assign trd_o    = r_trd;
  assign mux2_o   = r_mux2;
  assign wren_o   = r_wren;
  assign wrc_o    = r_wrc;

endmodule

// File: tb/tb_jpeg_dct_seq.sv
// Bench for jpeg_dct_seq: two instances (DCT_LAT=3 and DCT_LAT=1) checked cycle by
// cycle against per-block timelines built from the schedule rules.
module tb_jpeg_dct_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start [2];
  logic       abort [2];
  logic       busy [2], done [2], rden [2], reg1en [2], mux1 [2], dcten [2];
  logic       twr [2], trd [2], wren [2];
  logic [5:0] rdc [2];
  logic [1:0] mux2 [2];
  logic [4:0] wrc [2];

  int checks = 0;
  int errors = 0;

  // {busy,done,rden,reg1en,mux1,dcten,twr,trd,wren,rdc[5:0],mux2[1:0],wrc[4:0]}
  logic [21:0] m_vec [2][64];
  int          tend [2];

  always #5 clk = ~clk;

  jpeg_dct_seq #(.DCT_LAT(3)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .start_i(start[0]), .abort_i(abort[0]),
    .busy_o(busy[0]), .done_o(done[0]), .rdc_o(rdc[0]), .rden_o(rden[0]),
    .reg1en_o(reg1en[0]), .mux1_o(mux1[0]), .dcten_o(dcten[0]), .twr_o(twr[0]),
    .trd_o(trd[0]), .mux2_o(mux2[0]), .wren_o(wren[0]), .wrc_o(wrc[0])
  );

  jpeg_dct_seq #(.DCT_LAT(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start[1]), .abort_i(abort[1]),
    .busy_o(busy[1]), .done_o(done[1]), .rdc_o(rdc[1]), .rden_o(rden[1]),
    .reg1en_o(reg1en[1]), .mux1_o(mux1[1]), .dcten_o(dcten[1]), .twr_o(twr[1]),
    .trd_o(trd[1]), .mux2_o(mux2[1]), .wren_o(wren[1]), .wrc_o(wrc[1])
  );

  task automatic build_model(input int d, input int dl);
    int t0, w;
    logic [21:0] v;
    t0 = 17 + dl;
    tend[d] = t0 + 33 + dl;
    for (int t = 0; t < 64; t++) m_vec[d][t] = '0;
    for (int t = 0; t < tend[d]; t++) begin
      v = m_vec[d][t];
      v[21] = 1'b1;
      v[12:7] = (t <= 15) ? 6'(t) : 6'd15;
      v[19] = (t <= 15);
      v[17] = (t >= t0);
      m_vec[d][t] = v;
    end
    for (int i = 0; i < 8; i++) begin
      m_vec[d][2*i+1][18] = 1'b1;
      m_vec[d][2+2*i][16] = 1'b1;
      m_vec[d][2+2*i+dl][15] = 1'b1;
    end
    for (int j = 0; j < 8; j++) begin
      m_vec[d][t0+4*j][14] = 1'b1;
      m_vec[d][t0+4*j+1][16] = 1'b1;
      for (int m = 0; m < 4; m++) begin
        w = t0 + 4*j + 1 + dl + m;
        v = m_vec[d][w];
        v[13] = 1'b1;
        v[6:5] = 2'(m);
        v[4:0] = 5'(4*j + m);
        m_vec[d][w] = v;
      end
    end
    m_vec[d][tend[d]][20] = 1'b1;
  endtask

  function automatic logic [21:0] obs_vec(input int d);
    return {busy[d], done[d], rden[d], reg1en[d], mux1[d], dcten[d], twr[d], trd[d],
            wren[d], rdc[d], mux2[d], wrc[d]};
  endfunction

  function automatic logic [21:0] exp_vec(input int d, input int t);
    if (t >= 0 && t <= tend[d]) return m_vec[d][t];
    return '0;
  endfunction

  // Address fields are only defined on write cycles, and rdc in the done cycle is free.
  function automatic logic [21:0] msk(input int d, input int t, input logic [21:0] v);
    logic [21:0] r;
    r = v;
    if (t >= 0 && t <= tend[d]) begin
      if (!m_vec[d][t][13]) r[6:0] = '0;
      if (t == tend[d]) r[12:7] = '0;
    end
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin start[d] = 1'b0; abort[d] = 1'b0; end
    #2;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs_vec(d) !== 22'd0) begin
        errors++;
        $display("FAIL reset_async dut%0d: got %h expected %h", d, obs_vec(d), 22'd0);
      end
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs_vec(d) !== 22'd0) begin
          errors++;
          $display("FAIL reset_idle dut%0d c=%0d: got %h expected %h", d, c, obs_vec(d), 22'd0);
        end
      end
    end
  endtask

  task automatic test_block();
    logic [21:0] o, e;
    repeat ($urandom_range(0, 3)) @(negedge clk);
    start[0] = 1'b1;
    for (int t = 0; t <= tend[0] + 1; t++) begin
      @(negedge clk);
      start[0] = 1'b0;
      o = msk(0, t, obs_vec(0));
      e = msk(0, t, exp_vec(0, t));
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL block t=%0d: got %h expected %h", t, o, e);
      end
    end
  endtask

  task automatic test_start_ignored();
    logic [21:0] o, e;
    int tr;
    tr = $urandom_range(20, 50);
    start[0] = 1'b1;
    for (int t = 0; t <= tend[0] + 3; t++) begin
      @(negedge clk);
      start[0] = (t == 10) || (t == tr) || (t == tend[0]);
      o = msk(0, t, obs_vec(0));
      e = msk(0, t, exp_vec(0, t));
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL start_ignored t=%0d: got %h expected %h", t, o, e);
      end
    end
    start[0] = 1'b0;
  endtask

  task automatic test_abort(input int ta);
    logic [21:0] o, e;
    start[0] = 1'b1;
    for (int t = 0; t <= ta + 3; t++) begin
      @(negedge clk);
      start[0] = (t == ta) ? 1'($urandom_range(0, 1)) : 1'b0;
      abort[0] = (t == ta);
      o = msk(0, t, obs_vec(0));
      e = (t <= ta) ? msk(0, t, exp_vec(0, t)) : 22'd0;
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL abort ta=%0d t=%0d: got %h expected %h", ta, t, o, e);
      end
    end
    start[0] = 1'b1;
    for (int t = 0; t <= tend[0] + 1; t++) begin
      @(negedge clk);
      start[0] = 1'b0;
      o = msk(0, t, obs_vec(0));
      e = msk(0, t, exp_vec(0, t));
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL abort_restart t=%0d: got %h expected %h", t, o, e);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [21:0] o, e;
    start[0] = 1'b1;
    for (int t = 0; t <= 40; t++) begin
      @(negedge clk);
      start[0] = 1'b0;
      o = msk(0, t, obs_vec(0));
      e = msk(0, t, exp_vec(0, t));
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL pre_reset t=%0d: got %h expected %h", t, o, e);
      end
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (obs_vec(0) !== 22'd0) begin
      errors++;
      $display("FAIL midcycle_reset: got %h expected %h", obs_vec(0), 22'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++;
      if (obs_vec(0) !== 22'd0) begin
        errors++;
        $display("FAIL post_reset_idle c=%0d: got %h expected %h", c, obs_vec(0), 22'd0);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [21:0] o, e;
    start[1] = 1'b1;
    for (int b = 0; b < 2; b++) begin
      for (int t = 0; t <= tend[1] + 1; t++) begin
        @(negedge clk);
        start[1] = (b == 0) && (t == tend[1] + 1);
        o = msk(1, t, obs_vec(1));
        e = msk(1, t, exp_vec(1, t));
        checks++;
        if (o !== e) begin
          errors++;
          $display("FAIL back_to_back blk=%0d t=%0d: got %h expected %h", b, t, o, e);
        end
      end
    end
    start[1] = 1'b0;
  endtask

  initial begin
    build_model(0, 3);
    build_model(1, 1);
    test_reset();
    test_block();
    test_block();
    test_start_ignored();
    test_abort(30);
    test_abort($urandom_range(1, tend[0] - 1));
    test_async_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
